// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register-bank slave: address map, key
// values, lock FSM states and STATUS bit positions.
package reg_bank_pkg;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_CTRL    = 8'h01;
  localparam logic [7:0] ADDR_STATUS  = 8'h02;
  localparam logic [7:0] ADDR_KEY     = 8'h03;
  localparam logic [7:0] ADDR_CNT     = 8'h04;
  localparam logic [7:0] ADDR_GP_BASE = 8'h10;

  localparam logic [15:0] KEY_ARM       = 16'hA5A5;
  localparam logic [15:0] KEY_OPEN      = 16'h5A5A;
  localparam logic [15:0] UNMAPPED_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARMED  = 2'd1,
    OPEN   = 2'd2
  } lock_state_t;

  localparam int ST_W         = 4;
  localparam int ST_GP_DENIED = 0;
  localparam int ST_UNMAPPED  = 1;
  localparam int ST_CNT_WRAP  = 2;
  localparam int ST_AUTOLOCK  = 3;

endpackage

// File: rtl/reg_bank_lock_fsm.sv
// Key-sequence lock FSM (LOCKED -> ARMED -> OPEN). With REG_BANK_AUTOLOCK_EN
// defined, an idle counter relocks OPEN after AUTOLOCK_CYCLES quiet cycles.
module reg_bank_lock_fsm
  import reg_bank_pkg::*;
#(
  parameter int AUTOLOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_wr,
  input  logic [15:0] key_data,
  input  logic        gp_wr_accepted,
  output lock_state_t state,
  output logic        autolock_evt
);

  lock_state_t state_q, state_d;
  logic        timeout;

`ifdef REG_BANK_AUTOLOCK_EN
  logic [15:0] idle_q, idle_d;

  // Any cycle outside OPEN clears the count, which covers the entry reset.
  always_comb begin
    timeout = (state_q == OPEN) && !gp_wr_accepted &&
              (idle_q == 16'(AUTOLOCK_CYCLES - 1));
    idle_d  = ((state_q != OPEN) || gp_wr_accepted) ? 16'd0 : idle_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= 16'd0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_cfg;
  assign timeout    = 1'b0;
  assign unused_cfg = gp_wr_accepted ^ (AUTOLOCK_CYCLES == 0);
`endif

  // A KEY write in the timeout cycle takes priority over the autolock.
  always_comb begin
    state_d      = state_q;
    autolock_evt = 1'b0;
    if (key_wr) begin
      case (state_q)
        LOCKED:  state_d = (key_data == KEY_ARM)  ? ARMED : LOCKED;
        ARMED:   state_d = (key_data == KEY_OPEN) ? OPEN  : LOCKED;
        default: state_d = LOCKED;
      endcase
    end else if (timeout) begin
      state_d      = LOCKED;
      autolock_evt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOCKED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/reg_bank_slave.sv
// Register-bank slave: ID, CTRL, W1C STATUS, KEY lock, cycle counter and
// lock-protected GP registers. Optional autolock via REG_BANK_AUTOLOCK_EN.
module reg_bank_slave
  import reg_bank_pkg::*;
#(
  parameter int          NUM_GP          = 8,
  parameter logic [15:0] ID_VALUE        = 16'hC0DE,
  parameter int          AUTOLOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        irq
);

  localparam logic [4:0] GP_LIMIT = 5'(NUM_GP);

  logic [15:0]             ctrl_q, ctrl_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             data_out_q, data_out_d;
  logic [ST_W-1:0]         status_q, status_d;
  logic [NUM_GP-1:0][15:0] gp_q, gp_d;
  logic                    irq_q, irq_d;

  logic        gp_hit, mapped, key_wr, gp_wr, gp_wr_accepted, autolock_evt;
  logic [15:0] rdata;
  lock_state_t lock_state;

  assign gp_hit         = (address[7:4] == ADDR_GP_BASE[7:4]) &&
                          ({1'b0, address[3:0]} < GP_LIMIT);
  assign mapped         = gp_hit || (address <= ADDR_CNT);
  assign key_wr         = write && (address == ADDR_KEY);
  assign gp_wr          = write && gp_hit;
  assign gp_wr_accepted = gp_wr && (lock_state == OPEN);

  reg_bank_lock_fsm #(
    .AUTOLOCK_CYCLES(AUTOLOCK_CYCLES)
  ) u_lock (
    .clk           (clk),
    .rst           (rst),
    .key_wr        (key_wr),
    .key_data      (data_in),
    .gp_wr_accepted(gp_wr_accepted),
    .state         (lock_state),
    .autolock_evt  (autolock_evt)
  );

  always_comb begin
    rdata = UNMAPPED_DATA;
    case (address)
      ADDR_ID:     rdata = ID_VALUE;
      ADDR_CTRL:   rdata = ctrl_q;
      ADDR_STATUS: rdata = {{(16-ST_W){1'b0}}, status_q};
      ADDR_KEY:    rdata = {14'b0, lock_state};
      ADDR_CNT:    rdata = cnt_q;
      default:     rdata = UNMAPPED_DATA;
    endcase
    for (int i = 0; i < NUM_GP; i++)
      if (gp_hit && (address[3:0] == 4'(i))) rdata = gp_q[i];
  end

  // Set events are OR-ed in after the W1C mask so a same-cycle set wins.
  always_comb begin
    ctrl_d     = ctrl_q;
    gp_d       = gp_q;
    status_d   = status_q;
    cnt_d      = cnt_q + 16'd1;
    data_out_d = write ? data_out_q : rdata;

    if (write && (address == ADDR_CTRL))   ctrl_d   = data_in;
    if (write && (address == ADDR_STATUS)) status_d = status_q & ~data_in[ST_W-1:0];
    for (int i = 0; i < NUM_GP; i++)
      if (gp_wr_accepted && (address[3:0] == 4'(i))) gp_d[i] = data_in;

    status_d[ST_GP_DENIED] = status_d[ST_GP_DENIED] | (gp_wr && !gp_wr_accepted);
    status_d[ST_UNMAPPED]  = status_d[ST_UNMAPPED]  | !mapped;
    status_d[ST_CNT_WRAP]  = status_d[ST_CNT_WRAP]  | (cnt_q == 16'hFFFF);
    status_d[ST_AUTOLOCK]  = status_d[ST_AUTOLOCK]  | autolock_evt;

    irq_d = |(status_d[2:0] & ctrl_d[2:0]);
`ifdef REG_BANK_AUTOLOCK_EN
    irq_d = irq_d | (status_d[ST_AUTOLOCK] & ctrl_d[3]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      cnt_q      <= '0;
      gp_q       <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
      gp_q       <= gp_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_reg_bank_slave.sv
// Bench for reg_bank_slave: directed vector table, hand sequences for counter
// wrap and lock/autolock (REG_BANK_AUTOLOCK_EN), then random vs. a reference model.
module tb_reg_bank_slave;

  localparam int NUM_GP   = 8;
  localparam int AUTOLOCK = 64;
`ifdef REG_BANK_AUTOLOCK_EN
  localparam bit AL_EN = 1'b1;
`else
  localparam bit AL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bank_slave #(
    .NUM_GP(NUM_GP), .ID_VALUE(16'hC0DE), .AUTOLOCK_CYCLES(AUTOLOCK)
  ) dut (
    .clk(clk), .rst(rst), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state, updated once per clock.
  logic [15:0] m_ctrl, m_cnt, m_dout, m_lock;
  logic [3:0]  m_st;
  logic [15:0] m_gp [16];
  int          m_idle;
  bit          m_irq;

  task automatic model_reset();
    m_ctrl = 0; m_cnt = 0; m_dout = 0; m_lock = 0; m_st = 0;
    m_idle = 0; m_irq = 0;
    for (int i = 0; i < 16; i++) m_gp[i] = 0;
  endtask

  task automatic model_step(bit w, logic [7:0] a, logic [15:0] d);
    bit          is_gp, mapped, gp_acc;
    logic [15:0] rd;
    logic [3:0]  set_bits;
    is_gp    = (a >= 8'h10) && (int'(a) < 16 + NUM_GP);
    mapped   = (a <= 8'h04) || is_gp;
    set_bits = 0;
    gp_acc   = 0;
    if (!mapped)    rd = 16'hDEAD;
    else if (is_gp) rd = m_gp[a - 8'h10];
    else if (a == 0) rd = 16'hC0DE;
    else if (a == 1) rd = m_ctrl;
    else if (a == 2) rd = {12'b0, m_st};
    else if (a == 3) rd = m_lock;
    else             rd = m_cnt;
    if (!w) m_dout = rd;
    if (!mapped) set_bits[1] = 1;
    if (m_cnt == 16'hFFFF) set_bits[2] = 1;
    m_cnt = m_cnt + 1;
    if (w && is_gp) begin
      if (m_lock == 2) begin m_gp[a - 8'h10] = d; gp_acc = 1; end
      else set_bits[0] = 1;
    end
    if (w && a == 1) m_ctrl = d;
    if (w && a == 2) m_st = m_st & ~d[3:0];
    if (w && a == 3) begin
      if (m_lock == 0 && d == 16'hA5A5)      m_lock = 1;
      else if (m_lock == 1 && d == 16'h5A5A) begin m_lock = 2; m_idle = 0; end
      else                                   m_lock = 0;
    end else if (m_lock == 2) begin
      if (gp_acc) m_idle = 0;
      else begin
        m_idle++;
        if (AL_EN && m_idle == AUTOLOCK) begin m_lock = 0; set_bits[3] = 1; end
      end
    end
    m_st  = m_st | set_bits;
    m_irq = (|(m_st[2:0] & m_ctrl[2:0])) | (AL_EN & m_st[3] & m_ctrl[3]);
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(bit w, logic [7:0] a, logic [15:0] d);
    write = w; address = a; data_in = d;
    @(posedge clk); #1;
    model_step(w, a, d);
    chk("model_dout", data_out, m_dout);
    chk("model_irq", {15'b0, irq}, {15'b0, m_irq});
  endtask

  // Reset asserted alongside a random access: reset must win.
  task automatic do_reset();
    rst = 1; write = 1'($urandom); address = 8'($urandom); data_in = 16'($urandom);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_dout;
    bit          exp_irq;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit w, logic [7:0] a, logic [15:0] d,
                              logic [15:0] e, bit ei, string n);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp_dout = e; v.exp_irq = ei; v.name = n;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; write = 0; address = 0; data_in = 0;

    add(0, 8'h00, 16'h0000, 16'hC0DE, 0, "id_read");
    add(0, 8'h01, 16'h0000, 16'h0000, 0, "ctrl_reset");
    add(0, 8'h03, 16'h0000, 16'h0000, 0, "key_reset");
    add(1, 8'h10, 16'h1234, 16'h0000, 0, "gp_wr_locked_hold");
    add(0, 8'h10, 16'h0000, 16'h0000, 0, "gp_locked_rb");
    add(0, 8'h02, 16'h0000, 16'h0001, 0, "status_gp_denied");
    add(1, 8'h02, 16'h0001, 16'h0001, 0, "w1c_hold");
    add(0, 8'h02, 16'h0000, 16'h0000, 0, "status_cleared");
    add(1, 8'h03, 16'hA5A5, 16'h0000, 0, "key_arm");
    add(1, 8'h03, 16'h5A5A, 16'h0000, 0, "key_open");
    add(0, 8'h03, 16'h0000, 16'h0002, 0, "key_reads_open");
    add(1, 8'h10, 16'h1234, 16'h0002, 0, "gp_wr_open");
    add(0, 8'h10, 16'h0000, 16'h1234, 0, "gp_open_rb");
    add(1, 8'h03, 16'h0000, 16'h1234, 0, "key_relock");
    add(0, 8'h03, 16'h0000, 16'h0000, 0, "key_reads_locked");
    add(1, 8'h03, 16'hA5A5, 16'h0000, 0, "key_arm2");
    add(1, 8'h03, 16'h1111, 16'h0000, 0, "key_bad");
    add(0, 8'h03, 16'h0000, 16'h0000, 0, "key_bad_locked");
    add(1, 8'h11, 16'hBEEF, 16'h0000, 0, "gp_wr_dropped");
    add(0, 8'h11, 16'h0000, 16'h0000, 0, "gp_dropped_rb");
    add(0, 8'h02, 16'h0000, 16'h0001, 0, "status_bit0");
    add(1, 8'h02, 16'hFFFF, 16'h0001, 0, "status_clear_all");
    add(1, 8'h01, 16'h0002, 16'h0001, 0, "ctrl_wr");
    add(0, 8'h80, 16'h0000, 16'hDEAD, 1, "unmapped_read_irq");
    add(1, 8'h02, 16'h0002, 16'hDEAD, 0, "w1c_unmapped");
    add(0, 8'h18, 16'h0000, 16'hDEAD, 1, "gp_past_end");
    add(1, 8'h00, 16'hFFFF, 16'hDEAD, 1, "id_wr_ignored");
    add(0, 8'h00, 16'h0000, 16'hC0DE, 1, "id_unchanged");

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].a, tbl[i].d);
      chk(tbl[i].name, data_out, tbl[i].exp_dout);
      chk({tbl[i].name, "_irq"}, {15'b0, irq}, {15'b0, tbl[i].exp_irq});
    end

    // Counter wrap coinciding with a W1C of the wrap bit: the set wins.
    step(1, 8'h01, 16'h0004);
    step(1, 8'h02, 16'hFFFF);
    while (m_cnt != 16'hFFFF) step(0, 8'h00, 16'h0000);
    step(1, 8'h02, 16'h0004);
    chk("wrap_irq", {15'b0, irq}, 16'h0001);
    step(0, 8'h02, 16'h0000);
    chk("wrap_set_wins", data_out & 16'h0004, 16'h0004);
    step(0, 8'h04, 16'h0000);
    chk("cnt_after_wrap", data_out, 16'h0001);

    // Idle behaviour in OPEN.
    step(1, 8'h03, 16'h0000);
    step(1, 8'h02, 16'hFFFF);
    step(1, 8'h01, 16'h0008);
    step(1, 8'h03, 16'hA5A5);
    step(1, 8'h03, 16'h5A5A);
`ifdef REG_BANK_AUTOLOCK_EN
    for (int i = 0; i < 62; i++) step(0, 8'h03, 16'h0000);
    step(1, 8'h10, 16'h7777);
    for (int i = 0; i < 63; i++) step(0, 8'h03, 16'h0000);
    chk("al_restarted", data_out, 16'h0002);
    step(0, 8'h03, 16'h0000);
    chk("al_fire_edge", data_out, 16'h0002);
    step(0, 8'h03, 16'h0000);
    chk("al_locked", data_out, 16'h0000);
    chk("al_irq", {15'b0, irq}, 16'h0001);
    step(0, 8'h02, 16'h0000);
    chk("al_status3", data_out & 16'h0008, 16'h0008);
`else
    for (int i = 0; i < 200; i++) step(0, 8'h03, 16'h0000);
    chk("open_persists", data_out, 16'h0002);
    step(0, 8'h02, 16'h0000);
    chk("no_status3", data_out & 16'h0008, 16'h0000);
`endif

    // Random accesses against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  a;
      logic [15:0] d;
      bit          w;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 8'($urandom_range(0, 4));
        5, 6:          a = 8'(16 + $urandom_range(0, NUM_GP - 1));
        7:             a = 8'($urandom_range(16 + NUM_GP, 31));
        8:             a = 8'($urandom);
        default:       a = 8'h03;
      endcase
      w = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       d = 16'hA5A5;
        1:       d = 16'h5A5A;
        default: d = 16'($urandom);
      endcase
      step(w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
